// File: rtl/div_issue_queue.sv
// div_issue_queue
//   Buffered issue/retire stage wrapped around a combinational 8-bit unsigned
//   divider array. Requests {num1, num2, tag} queue in a DEPTH-entry FIFO and
//   then move into S1, the operand register that drives the divider. From
//   there they move into S2, the result register that faces writeback.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid/in_ready       request handshake (in_ready from registered count)
//     in_num1/in_num2/in_tag  dividend, divisor, opaque tag
//     out_valid/out_ready     result handshake; out_* hold while stalled
//     out_result/out_rest     quotient / remainder
//     out_tag, out_dz         request tag, divide-by-zero flag
//     count                   FIFO occupancy (S1/S2 not included)
//
//   Build option
//     DIVQ_ZERO_CHECK_EN  when defined, a zero divisor gives out_dz=1 and a
//                         zero quotient and remainder. When undefined,
//                         out_dz is tied to 0 and the raw divider outputs
//                         (0xFF, num1) pass through unchanged.

// One restoring-division row. It shifts in the next dividend bit and
// subtracts the divisor when the trial value is large enough.
module div_row (
    input  logic [7:0] rem_in,
    input  logic       nbit,
    input  logic [7:0] dvsr,
    output logic       qbit,
    output logic [7:0] rem_out
);
    logic [8:0] trial;
    logic [8:0] diff;

    // Both rem_in and the result stay below dvsr, or below 256 when
    // dvsr == 0, so the 9-bit trial value never overflows.
    assign trial   = {rem_in, nbit};
    assign diff    = trial - {1'b0, dvsr};
    assign qbit    = (trial >= {1'b0, dvsr});
    assign rem_out = qbit ? diff[7:0] : trial[7:0];
endmodule

// Combinational 8-bit unsigned divider built from 8 chained rows. A zero
// divisor makes every row subtract 0, which gives quotient 0xFF and
// remainder num1.
module divisor8b (
    input  logic [7:0] num1,
    input  logic [7:0] num2,
    output logic [7:0] result,
    output logic [7:0] rest
);
    logic [8:0][7:0] rem_chain;

    assign rem_chain[0] = 8'h00;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_row
            div_row u_row (
                .rem_in  (rem_chain[i]),
                .nbit    (num1[7-i]),
                .dvsr    (num2),
                .qbit    (result[7-i]),
                .rem_out (rem_chain[i+1])
            );
        end
    endgenerate

    assign rest = rem_chain[8];
endmodule

module div_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_num1,
    input  logic [7:0]               in_num2,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_result,
    output logic [7:0]               out_rest,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_dz,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [7:0]       num1;
        logic [7:0]       num2;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    req_t            s1;
    logic            s1_v;

    logic            push;
    logic            pop;
    logic            s2_load;
    logic            fifo_ne;
    logic [7:0]      div_q;
    logic [7:0]      div_r;

    // in_ready depends only on the registered count. A full FIFO refuses a
    // push even in a cycle where it also pops.
    assign in_ready = (count != CW'(DEPTH));
    assign fifo_ne  = (count != '0);
    assign push     = in_valid && in_ready;
    assign s2_load  = s1_v && (!out_valid || out_ready);
    assign pop      = fifo_ne && (!s1_v || s2_load);

    // FIFO storage. It has no reset because count and the pointers define
    // which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{num1: in_num1, num2: in_num2, tag: in_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // S1 reads only from the FIFO, so a request pushed at one edge reaches
    // S1 at the next edge at the earliest (no fall-through).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1   <= '0;
        end else if (pop) begin
            s1_v <= 1'b1;
            s1   <= mem[rd_ptr];
        end else if (s2_load) begin
            s1_v <= 1'b0;
        end
    end

    divisor8b u_div (
        .num1   (s1.num1),
        .num2   (s1.num2),
        .result (div_q),
        .rest   (div_r)
    );

    // S2: result register. It loads from S1 whenever it is empty or being
    // drained, and holds its contents while writeback stalls.
`ifdef DIVQ_ZERO_CHECK_EN
    logic zero_div;
    assign zero_div = (s1.num2 == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rest   <= '0;
            out_tag    <= '0;
            out_dz     <= 1'b0;
        end else if (s2_load) begin
            out_valid  <= 1'b1;
            out_result <= zero_div ? 8'h00 : div_q;
            out_rest   <= zero_div ? 8'h00 : div_r;
            out_tag    <= s1.tag;
            out_dz     <= zero_div;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end
`else
    assign out_dz = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rest   <= '0;
            out_tag    <= '0;
        end else if (s2_load) begin
            out_valid  <= 1'b1;
            out_result <= div_q;
            out_rest   <= div_r;
            out_tag    <= s1.tag;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue (DEPTH=4, TAG_W=3). A negedge monitor
// keeps an in-order scoreboard of accepted requests and checks every retired
// result against it. The main sequence checks latency, stall behaviour, the
// zero-divisor case, refusal of a push into a full FIFO, pointer wrap and
// asynchronous reset, using hand-computed values.
module tb_div_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_num1 = '0;
    logic [7:0]       in_num2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_result;
    logic [7:0]       out_rest;
    logic [TAG_W-1:0] out_tag;
    logic             out_dz;
    logic [2:0]       count;

    logic rdy_main = 1'b1;
    logic rnd_en   = 1'b0;
    logic rnd_bit  = 1'b1;
    assign out_ready = rnd_en ? rnd_bit : rdy_main;

    int n_chk  = 0;
    int n_pass = 0;
    int n_ret  = 0;

    typedef struct packed {
        logic             dz;
        logic [TAG_W-1:0] t;
        logic [7:0]       q;
        logic [7:0]       r;
    } exp_t;

    exp_t exp_q[$];

    div_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_num1(in_num1), .in_num2(in_num2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rest(out_rest),
        .out_tag(out_tag), .out_dz(out_dz), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tg, obs, exp_v);
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [TAG_W-1:0] t);
        exp_t e;
        e.t = t;
        if (b == 8'd0) begin
`ifdef DIVQ_ZERO_CHECK_EN
            e.q = 8'h00; e.r = 8'h00; e.dz = 1'b1;
`else
            e.q = 8'hFF; e.r = a;     e.dz = 1'b0;
`endif
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    // The handshake signals settle before the negedge and do not change until
    // after the next posedge, so sampling here describes the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                exp_q.push_back(model(in_num1, in_num2, in_tag));
            if (out_valid && out_ready) begin
                n_ret++;
                if (exp_q.size() == 0) chk("stale_result", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("retire", {12'd0, out_dz, out_tag, out_result, out_rest},
                        {12'd0, e.dz, e.t, e.q, e.r});
                end
            end
        end
    end

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] t);
        in_valid = 1'b1; in_num1 = a; in_num2 = b; in_tag = t;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready) break;
            if (w == 199) chk("send_timeout", 32'd0, 32'd1);
            step();
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tg);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 400) begin
            step();
            w++;
        end
        chk(tg, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tg);
        chk({tg, "_vld"},   32'(out_valid),  32'd0);
        chk({tg, "_rdy"},   32'(in_ready),   32'd1);
        chk({tg, "_cnt"},   32'(count),      32'd0);
        chk({tg, "_out"},   {13'd0, out_dz, out_tag, out_result, out_rest}, 32'd0);
    endtask

    initial begin
        int r;
        int ret0;
        int seen;
        logic [13:0] vpat;
        logic [7:0] q_tbl [8];
        q_tbl = '{8'd0, 8'd15, 8'd20, 8'd22, 8'd24, 8'd25, 8'd25, 8'd26};

        // reset state
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // single request 200/7 tag 5: pushed at edge k, visible after k+2
        send(8'd200, 8'd7, 3'd5);
        @(negedge clk);
        chk("lat_k_vld", 32'(out_valid), 32'd0);
        chk("lat_k_cnt", 32'(count), 32'd1);
        step();
        @(negedge clk);
        chk("lat_k1_vld", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("lat_k2_vld", 32'(out_valid), 32'd1);
        chk("single_res", {8'd0, 5'(out_tag), out_result, out_rest}, {8'd0, 5'd5, 8'd28, 8'd4});
        step();
        drain("single_drain");

        // back-to-back (i*30)/(i+1): valid during iterations 3..10
        vpat = '0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; in_num1 = 8'(c * 30); in_num2 = 8'(c + 1); in_tag = 3'(c);
            end else in_valid = 1'b0;
            @(negedge clk);
            vpat[c] = out_valid;
            if (c >= 3 && c <= 10) chk("b2b_q", 32'(out_result), 32'(q_tbl[c-3]));
            step();
        end
        chk("b2b_pattern", 32'(vpat), 32'h07F8);
        drain("b2b_drain");

        // stall: out_ready low, DEPTH+3 attempted, DEPTH+2 accepted
        rdy_main = 1'b0;
        ret0 = n_ret;
        r = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = 1'b1; in_num1 = 8'(100 + r); in_num2 = 8'(r + 3); in_tag = 3'(r);
            @(negedge clk);
            if (in_ready) r++;
            step();
        end
        chk("stall_acc", 32'(r), 32'(DEPTH + 2));
        @(negedge clk);
        chk("stall_rdy", 32'(in_ready), 32'd0);
        chk("stall_cnt", 32'(count), 32'(DEPTH));
        chk("stall_vld", 32'(out_valid), 32'd1);
        // oldest request 100/3, tag 0, has been held since about cycle 3
        chk("stall_hold", {8'd0, 5'(out_tag), out_result, out_rest}, {8'd0, 5'd0, 8'd33, 8'd1});
        step();
        in_valid = 1'b0;
        rdy_main = 1'b1;
        drain("stall_drain");
        chk("stall_retired", 32'(n_ret - ret0), 32'(DEPTH + 2));

        // divide by zero 77/0 tag 2
        send(8'd77, 8'd0, 3'd2);
        step(); step();
        @(negedge clk);
        chk("dz_vld", 32'(out_valid), 32'd1);
`ifdef DIVQ_ZERO_CHECK_EN
        chk("dz_res", {12'd0, out_dz, out_tag, out_result, out_rest}, {12'd0, 1'b1, 3'd2, 8'h00, 8'h00});
`else
        chk("dz_res", {12'd0, out_dz, out_tag, out_result, out_rest}, {12'd0, 1'b0, 3'd2, 8'hFF, 8'd77});
`endif
        step();
        drain("dz_drain");

        // full FIFO with a push and a pop in the same cycle: the push is refused
        rdy_main = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) send(8'(40 + i), 8'(i + 1), 3'(i));
        in_valid = 1'b1; in_num1 = 8'd50; in_num2 = 8'd5; in_tag = 3'd6;
        @(negedge clk);
        chk("full_rdy", 32'(in_ready), 32'd0);
        step();
        rdy_main = 1'b1;
        step();
        rdy_main = 1'b0;
        @(negedge clk);
        chk("full_popcnt", 32'(count), 32'(DEPTH - 1));
        step();
        in_valid = 1'b0;
        // pointer wrap with random out_ready
        rnd_en = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 20)), 3'(i));
        drain("wrap_drain");
        rnd_en = 1'b0;
        rdy_main = 1'b1;

        // asynchronous reset with 3 requests in flight
        rdy_main = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(90 + i), 8'd9, 3'(i + 1));
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        exp_q.delete();
        rdy_main = 1'b1;
        step(); step();
        #3 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_stale", 32'(seen), 32'd0);
        chk("post_rst_cnt", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
